// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
// Covers the stage register layouts, the reset and bubble defaults, and the PC step.
package pipe_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic        valid;
    } id_ex_t;

    // Branch targets are forced onto a word boundary before they reach the PC.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline stage register with hold (en=0) and bubble insertion (flush=1).
// Flush takes priority over the enable, so a bubble always lands even while the stage is held.
module pipe_reg #(
    parameter type T         = logic,
    parameter T    RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic flush,
    input  T     bubble,
    input  T     d,
    output T     q
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (flush) begin
            q <= bubble;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_ctrl.sv
// PC register plus IF/ID and ID/EX stage registers, applying hazard-unit stall/flush
// controls and EX redirects, with saturating stall and redirect counters.
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pc_en,
    input  logic             i_IF_ID_stall,
    input  logic             i_ID_EX_flush,
    input  logic             i_redirect,
    input  logic [31:0]      i_redirect_pc,
    input  logic [31:0]      i_imem_inst,
    input  logic [31:0]      i_ID_rs1_data,
    input  logic [31:0]      i_ID_rs2_data,
    input  logic [31:0]      i_ID_imm,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_ID_inst,
    output logic [31:0]      o_ID_pc,
    output logic             o_ID_valid,
    output logic [31:0]      o_EX_inst,
    output logic [31:0]      o_EX_pc,
    output logic [31:0]      o_EX_rs1_data,
    output logic [31:0]      o_EX_rs2_data,
    output logic [31:0]      o_EX_imm,
    output logic             o_EX_valid,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    // A bubble is a NOP marked invalid with all data cleared; it doubles as the reset value.
    localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc: 32'h0, valid: 1'b0};
    localparam id_ex_t ID_EX_BUBBLE = '{inst: NOP_INST, pc: 32'h0, rs1_data: 32'h0,
                                        rs2_data: 32'h0, imm: 32'h0, valid: 1'b0};

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    if_id_t           if_id_d;
    if_id_t           if_id_q;
    id_ex_t           id_ex_d;
    id_ex_t           id_ex_q;
    logic             ex_flush;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        pc_d = pc_q;
        if (i_redirect) begin
            pc_d = align_word(i_redirect_pc);
        end else if (i_pc_en) begin
            pc_d = pc_q + PC_STEP;  // wraps naturally from FFFF_FFFC to 0
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        if_id_d       = IF_ID_BUBBLE;
        if_id_d.inst  = i_imem_inst;
        if_id_d.pc    = pc_q;
        if_id_d.valid = 1'b1;
    end

    always_comb begin
        id_ex_d          = ID_EX_BUBBLE;
        id_ex_d.inst     = if_id_q.inst;
        id_ex_d.pc       = if_id_q.pc;
        id_ex_d.rs1_data = i_ID_rs1_data;
        id_ex_d.rs2_data = i_ID_rs2_data;
        id_ex_d.imm      = i_ID_imm;
        id_ex_d.valid    = if_id_q.valid;
    end

    // A redirect squashes both stages; it overrides the hazard unit's hold on IF/ID.
    assign ex_flush = i_redirect | i_ID_EX_flush;

    pipe_reg #(
        .T         (if_id_t),
        .RESET_VAL (IF_ID_BUBBLE)
    ) u_if_id (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (~i_IF_ID_stall),
        .flush  (i_redirect),
        .bubble (IF_ID_BUBBLE),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    pipe_reg #(
        .T         (id_ex_t),
        .RESET_VAL (ID_EX_BUBBLE)
    ) u_id_ex (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (1'b1),
        .flush  (ex_flush),
        .bubble (ID_EX_BUBBLE),
        .d      (id_ex_d),
        .q      (id_ex_q)
    );

    // Stall cycles are only counted when no redirect overrides the hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (i_redirect) begin
            if (flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end else if (i_IF_ID_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_pc          = pc_q;
    assign o_ID_inst     = if_id_q.inst;
    assign o_ID_pc       = if_id_q.pc;
    assign o_ID_valid    = if_id_q.valid;
    assign o_EX_inst     = id_ex_q.inst;
    assign o_EX_pc       = id_ex_q.pc;
    assign o_EX_rs1_data = id_ex_q.rs1_data;
    assign o_EX_rs2_data = id_ex_q.rs2_data;
    assign o_EX_imm      = id_ex_q.imm;
    assign o_EX_valid    = id_ex_q.valid;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Self-checking bench for pipe_front_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the front end.
module tb_pipe_front_ctrl;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] T_NOP      = 32'h0000_0013;
    localparam int          T_CNT_W    = 4;
    localparam int          CNT_MAX    = 15;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_pc_en;
    logic               i_IF_ID_stall;
    logic               i_ID_EX_flush;
    logic               i_redirect;
    logic [31:0]        i_redirect_pc;
    logic [31:0]        i_imem_inst;
    logic [31:0]        i_ID_rs1_data;
    logic [31:0]        i_ID_rs2_data;
    logic [31:0]        i_ID_imm;
    logic [31:0]        o_pc;
    logic [31:0]        o_ID_inst;
    logic [31:0]        o_ID_pc;
    logic               o_ID_valid;
    logic [31:0]        o_EX_inst;
    logic [31:0]        o_EX_pc;
    logic [31:0]        o_EX_rs1_data;
    logic [31:0]        o_EX_rs2_data;
    logic [31:0]        o_EX_imm;
    logic               o_EX_valid;
    logic [T_CNT_W-1:0] o_stall_cnt;
    logic [T_CNT_W-1:0] o_flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of the architectural front-end state.
    logic [31:0] m_pc, m_id_inst, m_id_pc, m_ex_inst, m_ex_pc, m_ex_rs1, m_ex_rs2, m_ex_imm;
    logic        m_id_valid, m_ex_valid;
    int          m_stall_cnt, m_flush_cnt;

    pipe_front_ctrl #(
        .RESET_PC (T_RESET_PC),
        .NOP_INST (T_NOP),
        .CNT_W    (T_CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pc_en       (i_pc_en),
        .i_IF_ID_stall (i_IF_ID_stall),
        .i_ID_EX_flush (i_ID_EX_flush),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_imem_inst   (i_imem_inst),
        .i_ID_rs1_data (i_ID_rs1_data),
        .i_ID_rs2_data (i_ID_rs2_data),
        .i_ID_imm      (i_ID_imm),
        .o_pc          (o_pc),
        .o_ID_inst     (o_ID_inst),
        .o_ID_pc       (o_ID_pc),
        .o_ID_valid    (o_ID_valid),
        .o_EX_inst     (o_EX_inst),
        .o_EX_pc       (o_EX_pc),
        .o_EX_rs1_data (o_EX_rs1_data),
        .o_EX_rs2_data (o_EX_rs2_data),
        .o_EX_imm      (o_EX_imm),
        .o_EX_valid    (o_EX_valid),
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
    );

    // Instruction memory returns the fetch address as the instruction word.
    assign i_imem_inst = o_pc;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_pc        = T_RESET_PC;
        m_id_inst   = T_NOP;
        m_id_pc     = 32'h0;
        m_id_valid  = 1'b0;
        m_ex_inst   = T_NOP;
        m_ex_pc     = 32'h0;
        m_ex_rs1    = 32'h0;
        m_ex_rs2    = 32'h0;
        m_ex_imm    = 32'h0;
        m_ex_valid  = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic ex_bubble();
        m_ex_inst  = T_NOP;
        m_ex_pc    = 32'h0;
        m_ex_rs1   = 32'h0;
        m_ex_rs2   = 32'h0;
        m_ex_imm   = 32'h0;
        m_ex_valid = 1'b0;
    endtask

    // Drive one cycle of controls, advance the model by the same rules, sample 1ns after the edge.
    task automatic tick(input logic en, input logic stall, input logic flush,
                        input logic redir, input logic [31:0] target);
        logic [31:0] r1, r2, im;
        r1 = $urandom;
        r2 = $urandom;
        im = $urandom;
        i_pc_en       = en;
        i_IF_ID_stall = stall;
        i_ID_EX_flush = flush;
        i_redirect    = redir;
        i_redirect_pc = target;
        i_ID_rs1_data = r1;
        i_ID_rs2_data = r2;
        i_ID_imm      = im;
        @(posedge i_clk);
        if (redir) begin
            ex_bubble();
            m_id_inst  = T_NOP;
            m_id_pc    = 32'h0;
            m_id_valid = 1'b0;
            m_pc       = {target[31:2], 2'b00};
            if (m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end else begin
            if (flush) begin
                ex_bubble();
            end else begin
                m_ex_inst  = m_id_inst;
                m_ex_pc    = m_id_pc;
                m_ex_rs1   = r1;
                m_ex_rs2   = r2;
                m_ex_imm   = im;
                m_ex_valid = m_id_valid;
            end
            if (stall) begin
                if (m_stall_cnt < CNT_MAX) m_stall_cnt++;
            end else begin
                m_id_inst  = m_pc;
                m_id_pc    = m_pc;
                m_id_valid = 1'b1;
            end
            if (en) m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        i_pc_en = 1'b0; i_IF_ID_stall = 1'b0; i_ID_EX_flush = 1'b0; i_redirect = 1'b0;
        i_redirect_pc = 32'h0; i_ID_rs1_data = 32'h0; i_ID_rs2_data = 32'h0; i_ID_imm = 32'h0;
        #1 i_rst_n = 1'b0;
        #11;
        n_checks++;
        if (o_pc !== T_RESET_PC) begin
            n_errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, T_RESET_PC);
        end
        n_checks++;
        if ({o_ID_inst, o_EX_inst} !== {T_NOP, T_NOP}) begin
            n_errors++; $display("FAIL reset_inst: got %h/%h expected %h", o_ID_inst, o_EX_inst, T_NOP);
        end
        n_checks++;
        if ({o_ID_pc, o_EX_pc, o_EX_rs1_data, o_EX_rs2_data, o_EX_imm, o_ID_valid, o_EX_valid} !== '0) begin
            n_errors++; $display("FAIL reset_data: got %h %h %h %h %h %b %b expected all 0",
                                 o_ID_pc, o_EX_pc, o_EX_rs1_data, o_EX_rs2_data, o_EX_imm, o_ID_valid, o_EX_valid);
        end
        n_checks++;
        if ({o_stall_cnt, o_flush_cnt} !== '0) begin
            n_errors++; $display("FAIL reset_cnt: got %h/%h expected 0/0", o_stall_cnt, o_flush_cnt);
        end
        model_reset();
        i_rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc, o_ID_inst, o_ID_valid} !== {32'h104, 32'h100, 32'h100, 1'b1}) begin
            n_errors++; $display("FAIL first_fetch: got pc=%h id_pc=%h id_inst=%h v=%b expected 104/100/100/1",
                                 o_pc, o_ID_pc, o_ID_inst, o_ID_valid);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_EX_pc, o_EX_valid} !== {32'h108, 32'h100, 1'b1}) begin
            n_errors++; $display("FAIL first_ex: got pc=%h ex_pc=%h v=%b expected 108/100/1",
                                 o_pc, o_EX_pc, o_EX_valid);
        end
    endtask

    task automatic test_load_use();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (o_pc !== 32'h10C) begin
            n_errors++; $display("FAIL lu_setup_pc: got %h expected %h", o_pc, 32'h10C);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc, o_ID_inst, o_ID_valid} !== {32'h10C, 32'h108, 32'h108, 1'b1}) begin
            n_errors++; $display("FAIL lu_hold: got pc=%h id_pc=%h id_inst=%h v=%b expected 10c/108/108/1",
                                 o_pc, o_ID_pc, o_ID_inst, o_ID_valid);
        end
        n_checks++;
        if ({o_EX_inst, o_EX_valid} !== {T_NOP, 1'b0}) begin
            n_errors++; $display("FAIL lu_bubble: got inst=%h v=%b expected 00000013/0", o_EX_inst, o_EX_valid);
        end
        n_checks++;
        if (o_stall_cnt !== 4'd1) begin
            n_errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", o_stall_cnt);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc, o_EX_pc, o_EX_valid} !== {32'h110, 32'h10C, 32'h108, 1'b1}) begin
            n_errors++; $display("FAIL lu_resume: got pc=%h id_pc=%h ex_pc=%h v=%b expected 110/10c/108/1",
                                 o_pc, o_ID_pc, o_EX_pc, o_EX_valid);
        end
    endtask

    task automatic test_redirect();
        tick(1'b1, 1'b1, 1'b0, 1'b1, 32'h203);
        n_checks++;
        if (o_pc !== 32'h200) begin
            n_errors++; $display("FAIL redir_pc: got %h expected %h", o_pc, 32'h200);
        end
        n_checks++;
        if ({o_ID_valid, o_EX_valid, o_ID_inst, o_EX_inst} !== {1'b0, 1'b0, T_NOP, T_NOP}) begin
            n_errors++; $display("FAIL redir_squash: got v=%b%b inst=%h/%h expected 00 nop/nop",
                                 o_ID_valid, o_EX_valid, o_ID_inst, o_EX_inst);
        end
        n_checks++;
        if ({o_flush_cnt, o_stall_cnt} !== {4'd1, 4'd1}) begin
            n_errors++; $display("FAIL redir_cnt: got flush=%0d stall=%0d expected 1/1", o_flush_cnt, o_stall_cnt);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc, o_ID_inst, o_ID_valid} !== {32'h204, 32'h200, 32'h200, 1'b1}) begin
            n_errors++; $display("FAIL redir_target_id: got pc=%h id_pc=%h id_inst=%h v=%b expected 204/200/200/1",
                                 o_pc, o_ID_pc, o_ID_inst, o_ID_valid);
        end
    endtask

    task automatic test_pc_wrap();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        n_checks++;
        if (o_pc !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_setup: got %h expected %h", o_pc, 32'hFFFF_FFFC);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
            n_errors++; $display("FAIL wrap_pc: got pc=%h id_pc=%h expected 00000000/fffffffc", o_pc, o_ID_pc);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0081);
        n_checks++;
        if ({o_pc, o_ID_valid, o_EX_valid} !== {32'h80, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL b2b_redir: got pc=%h v=%b%b expected 80/00", o_pc, o_ID_valid, o_EX_valid);
        end
        n_checks++;
        if (int'(o_flush_cnt) != m_flush_cnt) begin
            n_errors++; $display("FAIL b2b_flush_cnt: got %0d expected %0d", o_flush_cnt, m_flush_cnt);
        end
    endtask

    task automatic test_stall_saturation();
        logic [31:0] held_pc;
        held_pc = o_pc;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        n_checks++;
        if (o_stall_cnt !== 4'hF) begin
            n_errors++; $display("FAIL stall_sat: got %h expected f", o_stall_cnt);
        end
        n_checks++;
        if ({o_pc, o_EX_valid} !== {held_pc, 1'b0}) begin
            n_errors++; $display("FAIL stall_frozen: got pc=%h ex_v=%b expected %h/0", o_pc, o_EX_valid, held_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(7) == 0), $urandom);
            n_checks++;
            if (o_pc !== m_pc) begin
                n_errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, o_pc, m_pc);
            end
            n_checks++;
            if ({o_ID_inst, o_ID_pc, o_ID_valid} !== {m_id_inst, m_id_pc, m_id_valid}) begin
                n_errors++; $display("FAIL rnd_id[%0d]: got %h/%h/%b expected %h/%h/%b", i,
                                     o_ID_inst, o_ID_pc, o_ID_valid, m_id_inst, m_id_pc, m_id_valid);
            end
            n_checks++;
            if ({o_EX_inst, o_EX_pc, o_EX_valid} !== {m_ex_inst, m_ex_pc, m_ex_valid}) begin
                n_errors++; $display("FAIL rnd_ex[%0d]: got %h/%h/%b expected %h/%h/%b", i,
                                     o_EX_inst, o_EX_pc, o_EX_valid, m_ex_inst, m_ex_pc, m_ex_valid);
            end
            n_checks++;
            if ({o_EX_rs1_data, o_EX_rs2_data, o_EX_imm} !== {m_ex_rs1, m_ex_rs2, m_ex_imm}) begin
                n_errors++; $display("FAIL rnd_ops[%0d]: got %h/%h/%h expected %h/%h/%h", i,
                                     o_EX_rs1_data, o_EX_rs2_data, o_EX_imm, m_ex_rs1, m_ex_rs2, m_ex_imm);
            end
            n_checks++;
            if (int'(o_stall_cnt) != m_stall_cnt || int'(o_flush_cnt) != m_flush_cnt) begin
                n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", i,
                                     o_stall_cnt, o_flush_cnt, m_stall_cnt, m_flush_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        #3 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_pc, o_ID_inst, o_EX_inst} !== {T_RESET_PC, T_NOP, T_NOP}) begin
            n_errors++; $display("FAIL async_rst_pc_inst: got %h/%h/%h expected %h/%h/%h",
                                 o_pc, o_ID_inst, o_EX_inst, T_RESET_PC, T_NOP, T_NOP);
        end
        n_checks++;
        if ({o_ID_pc, o_EX_pc, o_EX_rs1_data, o_EX_rs2_data, o_EX_imm, o_ID_valid, o_EX_valid,
             o_stall_cnt, o_flush_cnt} !== '0) begin
            n_errors++; $display("FAIL async_rst_data: got %h %h %h %h %h %b %b %h %h expected all 0",
                                 o_ID_pc, o_EX_pc, o_EX_rs1_data, o_EX_rs2_data, o_EX_imm,
                                 o_ID_valid, o_EX_valid, o_stall_cnt, o_flush_cnt);
        end
        model_reset();
        #2 i_rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({o_pc, o_ID_pc, o_ID_valid} !== {32'h104, T_RESET_PC, 1'b1}) begin
            n_errors++; $display("FAIL async_rst_refetch: got pc=%h id_pc=%h v=%b expected 104/100/1",
                                 o_pc, o_ID_pc, o_ID_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_pc_wrap();
        test_back_to_back();
        test_stall_saturation();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
